scratch_spi_storage: RTL and testbench

//  Storage back end directly downstream of the MMU. Receives one held memory request at a time on the

---
 rtl/scratch_spi_storage_if.sv | 22 ++
 rtl/scratch_spi_storage.sv | 179 +++++++++++++++++
 tb/tb_scratch_spi_storage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/scratch_spi_storage_if.sv
// Request/response bus between the MMU and the storage back end; the MMU holds the
// request fields stable from memory_access until it sees out_valid.
interface scratch_spi_storage_if;
    logic        memory_access;
    logic        memory_is_writing;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [3:0]  mem_be;
    logic [31:0] d_out;
    logic        out_valid;
    logic        out_err;

    modport master (
        output memory_access, memory_is_writing, addr, d_in, mem_be,
        input  d_out, out_valid, out_err
    );

    modport slave (
        input  memory_access, memory_is_writing, addr, d_in, mem_be,
        output d_out, out_valid, out_err
    );
endinterface

// File: rtl/scratch_spi_storage.sv
// Scratch SRAM (0x1000-0x1FFF) plus SPI mode-0 external storage (0x2000+); one request at a time.
// Latency: error 1, SRAM 2, SPI 128*SPI_CLK_DIV+2 cycles; no backpressure, busy states ignore memory_access.
module scratch_spi_storage #(
    parameter int SRAM_WORDS  = 1024,
    parameter int SPI_CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    scratch_spi_storage_if.slave mem_if,
    output logic                 spi_sck_o,
    output logic                 spi_cs_n_o,
    output logic                 spi_mosi_o,
    input  logic                 spi_miso_i
);

    localparam int IDX_W = $clog2(SRAM_WORDS);
    localparam int DIV_W = (SPI_CLK_DIV > 1) ? $clog2(SPI_CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SRAM_ACC,
        SPI_SHIFT,
        SPI_END,
        DONE
    } state_t;

    state_t             state_q;
    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdat_q;
    logic [3:0]         be_q;
    logic [5:0]         bit_q;
    logic [DIV_W-1:0]   div_q;
    logic [62:0]        tx_q;
    logic [31:0]        rx_q;
    logic [31:0]        d_out_q;
    logic               out_valid_q;
    logic               out_err_q;
    logic               sck_q;
    logic               cs_n_q;
    logic               mosi_q;

    logic [31:0]        sram [SRAM_WORDS];

    logic               req_sram_d;
    logic               req_err_d;
    logic [63:0]        frame_d;

    always_comb begin
        req_sram_d = 1'b0;
        req_err_d  = 1'b0;
        if (mem_if.addr < 32'h0000_1000) begin
            req_err_d = 1'b1;
        end else if (mem_if.addr < 32'h0000_2000) begin
            req_sram_d = 1'b1;
        end else if (mem_if.addr[31:24] != 8'h00) begin
            req_err_d = 1'b1;
        end else if (mem_if.memory_is_writing && (mem_if.mem_be != 4'hF)) begin
            // External device only supports full-word writes.
            req_err_d = 1'b1;
        end
        frame_d = {(mem_if.memory_is_writing ? 8'h02 : 8'h03),
                   mem_if.addr[23:0],
                   (mem_if.memory_is_writing ? mem_if.d_in : 32'h0)};
    end

    // SRAM contents deliberately survive reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (state_q == SRAM_ACC && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    sram[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdat_q      <= '0;
            be_q        <= '0;
            bit_q       <= '0;
            div_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    out_err_q   <= 1'b0;
                    d_out_q     <= '0;
                    if (mem_if.memory_access) begin
                        wr_q   <= mem_if.memory_is_writing;
                        idx_q  <= mem_if.addr[IDX_W+1:2];
                        wdat_q <= mem_if.d_in;
                        be_q   <= mem_if.mem_be;
                        bit_q  <= '0;
                        div_q  <= '0;
                        if (req_err_d) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                        end else if (req_sram_d) begin
                            state_q <= SRAM_ACC;
                        end else begin
                            state_q <= SPI_SHIFT;
                            cs_n_q  <= 1'b0;
                            sck_q   <= 1'b0;
                            mosi_q  <= frame_d[63];
                            tx_q    <= frame_d[62:0];
                        end
                    end
                end

                SRAM_ACC: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    d_out_q     <= wr_q ? 32'h0 : sram[idx_q];
                end

                SPI_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (!sck_q) begin
                            // Rising SCK: sample MISO on this same edge.
                            sck_q <= 1'b1;
                            rx_q  <= {rx_q[30:0], spi_miso_i};
                        end else if (bit_q == 6'd63) begin
                            state_q <= SPI_END;
                            sck_q   <= 1'b0;
                            cs_n_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                        end else begin
                            sck_q  <= 1'b0;
                            bit_q  <= bit_q + 6'd1;
                            mosi_q <= tx_q[62];
                            tx_q   <= {tx_q[61:0], 1'b0};
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                SPI_END: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    d_out_q     <= wr_q ? 32'h0 : rx_q;
                end

                DONE: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_err_q   <= 1'b0;
                    d_out_q     <= '0;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_if.d_out     = d_out_q;
    assign mem_if.out_valid = out_valid_q;
    assign mem_if.out_err   = out_err_q;
    assign spi_sck_o        = sck_q;
    assign spi_cs_n_o       = cs_n_q;
    assign spi_mosi_o       = mosi_q;

endmodule

// File: tb/tb_scratch_spi_storage.sv
// Directed bench for scratch_spi_storage: SRAM, SPI read/write frames, error decode and async reset.
module tb_scratch_spi_storage;

    logic clk;
    logic rst;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    scratch_spi_storage_if bus ();

    scratch_spi_storage #(.SRAM_WORDS(1024), .SPI_CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_if     (bus),
        .spi_sck_o  (spi_sck),
        .spi_cs_n_o (spi_cs_n),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          rise_cnt;
    logic [63:0] mosi_cap;
    logic        cs_c0, cs_c1, cs_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request, hold it until out_valid, model the SPI slave meanwhile.
    task automatic run_req(input string tag, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           input logic [31:0] miso_word, input int exp_cyc,
                           input logic [31:0] exp_dout, input logic exp_err,
                           input bit hold_extra);
        int   cyc;
        bit   seen;
        logic prev_sck;
        logic [31:0] got_d;
        logic got_e;
        @(negedge clk);
        bus.memory_access     = 1'b1;
        bus.memory_is_writing = wr;
        bus.addr              = a;
        bus.d_in              = d;
        bus.mem_be            = be;
        rise_cnt = 0;
        mosi_cap = '0;
        cs_c0    = spi_cs_n;
        cs_c1    = 1'b1;
        cs_last  = 1'b1;
        prev_sck = spi_sck;
        spi_miso = 1'b0;
        cyc      = 0;
        seen     = 1'b0;
        got_d    = '0;
        got_e    = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) cs_c1 = spi_cs_n;
            if (cyc == exp_cyc - 1) cs_last = spi_cs_n;
            if (spi_sck && !prev_sck) begin
                rise_cnt++;
                mosi_cap = {mosi_cap[62:0], spi_mosi};
            end
            prev_sck = spi_sck;
            if (!spi_cs_n && !spi_sck && rise_cnt >= 32 && rise_cnt < 64)
                spi_miso = miso_word[63 - rise_cnt];
            else
                spi_miso = 1'b0;
            if (bus.out_valid) begin
                seen  = 1'b1;
                got_d = bus.d_out;
                got_e = bus.out_err;
            end
        end
        chk({tag, " out_valid seen"}, 64'(seen), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " d_out"}, 64'(got_d), 64'(exp_dout));
        chk({tag, " out_err"}, 64'(got_e), 64'(exp_err));
        if (hold_extra) @(negedge clk);
        bus.memory_access = 1'b0;
    endtask

    initial begin
        int pulses;
        rst                   = 1'b1;
        spi_miso              = 1'b0;
        bus.memory_access     = 1'b0;
        bus.memory_is_writing = 1'b0;
        bus.addr              = '0;
        bus.d_in              = '0;
        bus.mem_be            = '0;
        repeat (3) @(negedge clk);
        chk("rst d_out",     64'(bus.d_out), 64'h0);
        chk("rst out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst out_err",   64'(bus.out_err), 64'h0);
        chk("rst cs_n",      64'(spi_cs_n), 64'h1);
        chk("rst sck",       64'(spi_sck), 64'h0);
        chk("rst mosi",      64'(spi_mosi), 64'h0);
        rst = 1'b0;

        // SRAM full word, byte mask, top-word alias, low addr bits ignored
        run_req("sram wr 1004", 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 32'h0, 2, 32'h0, 1'b0, 1'b0);
        run_req("sram rd 1004", 1'b0, 32'h1004, 32'h0, 4'hF, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
        run_req("sram wr be2",  1'b1, 32'h1004, 32'h0000AB00, 4'b0010, 32'h0, 2, 32'h0, 1'b0, 1'b0);
        run_req("sram rd be2",  1'b0, 32'h1004, 32'h0, 4'hF, 32'h0, 2, 32'hDEADABEF, 1'b0, 1'b0);
        run_req("sram wr 1ffc", 1'b1, 32'h1FFC, 32'h11223344, 4'hF, 32'h0, 2, 32'h0, 1'b0, 1'b0);
        run_req("sram wr 1000", 1'b1, 32'h1000, 32'h55667788, 4'hF, 32'h0, 2, 32'h0, 1'b0, 1'b0);
        run_req("sram rd 1ffc", 1'b0, 32'h1FFC, 32'h0, 4'hF, 32'h0, 2, 32'h11223344, 1'b0, 1'b0);
        run_req("sram rd 1000", 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 2, 32'h55667788, 1'b0, 1'b0);
        run_req("sram rd 1006", 1'b0, 32'h1006, 32'h0, 4'hF, 32'h0, 2, 32'hDEADABEF, 1'b0, 1'b0);

        // External read and write frames
        run_req("ext rd", 1'b0, 32'h2010, 32'h0, 4'hF, 32'h12345678, 514, 32'h12345678, 1'b0, 1'b0);
        chk("ext rd sck rises", 64'(rise_cnt), 64'd64);
        chk("ext rd cmd",  64'(mosi_cap[63:56]), 64'h03);
        chk("ext rd addr", 64'(mosi_cap[55:32]), 64'h002010);
        chk("ext rd data", 64'(mosi_cap[31:0]),  64'h0);
        chk("ext rd cs_n c0",   64'(cs_c0), 64'h1);
        chk("ext rd cs_n c1",   64'(cs_c1), 64'h0);
        chk("ext rd cs_n c513", 64'(cs_last), 64'h1);

        run_req("ext wr", 1'b1, 32'h3000, 32'hCAFEF00D, 4'hF, 32'hFFFFFFFF, 514, 32'h0, 1'b0, 1'b0);
        chk("ext wr sck rises", 64'(rise_cnt), 64'd64);
        chk("ext wr cmd",  64'(mosi_cap[63:56]), 64'h02);
        chk("ext wr addr", 64'(mosi_cap[55:32]), 64'h003000);
        chk("ext wr data", 64'(mosi_cap[31:0]),  64'hCAFEF00D);

        // Decode errors
        run_req("err low", 1'b0, 32'h0800, 32'h0, 4'hF, 32'h0, 1, 32'h0, 1'b1, 1'b0);
        chk("err low sck", 64'(rise_cnt), 64'd0);
        chk("err low cs",  64'(cs_c1), 64'h1);
        run_req("err hi", 1'b1, 32'h0100_0000, 32'h12345678, 4'hF, 32'h0, 1, 32'h0, 1'b1, 1'b0);
        chk("err hi sck", 64'(rise_cnt), 64'd0);
        chk("err hi cs",  64'(cs_c1), 64'h1);
        run_req("err be", 1'b1, 32'h2000, 32'h12345678, 4'h3, 32'h0, 1, 32'h0, 1'b1, 1'b0);
        chk("err be sck", 64'(rise_cnt), 64'd0);
        chk("err be cs",  64'(cs_c1), 64'h1);

        // Async reset in the middle of an external read
        @(negedge clk);
        bus.memory_access     = 1'b1;
        bus.memory_is_writing = 1'b0;
        bus.addr              = 32'h2010;
        bus.mem_be            = 4'hF;
        repeat (100) @(negedge clk);
        chk("mid-frame cs_n", 64'(spi_cs_n), 64'h0);
        rst = 1'b1;
        #1;
        chk("async rst cs_n",      64'(spi_cs_n), 64'h1);
        chk("async rst sck",       64'(spi_sck), 64'h0);
        chk("async rst out_valid", 64'(bus.out_valid), 64'h0);
        bus.memory_access = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        rst = 1'b0;
        run_req("post-rst sram rd", 1'b0, 32'h1004, 32'h0, 4'hF, 32'h0, 2, 32'hDEADABEF, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        chk("no stray out_valid", 64'(pulses), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
